// File: rtl/gf_multi_squarer_if.sv
// Start/done handshake bundle for the repeated GF(2^M) squarer.
// The master drives start/din/k; the slave returns status and the result.
interface gf_multi_squarer_if #(
  parameter int M  = 8,
  parameter int KW = 4
);
  logic          start;
  logic [M-1:0]  din;
  logic [KW-1:0] k;
  logic          ready;
  logic          busy;
  logic          done;
  logic [M-1:0]  dout;

  modport master (output start, din, k, input ready, busy, done, dout);
  modport slave  (input start, din, k, output ready, busy, done, dout);
endinterface

// File: rtl/gf_multi_squarer.sv
// Sequential GF(2^M) repeated squarer: dout = din^(2^k), UNROLL squarings per clock.
// Polynomial basis, reduction modulo x^M + POLY.
module gf_multi_squarer #(
  parameter int           M      = 8,
  parameter logic [M-1:0] POLY   = 8'h1B,
  parameter int           KW     = 4,
  parameter int           UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst,
  gf_multi_squarer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [KW:0] UNR = (KW+1)'(UNROLL);

  state_t        r_state;
  state_t        w_state_next;
  logic [M-1:0]  r_acc;
  logic [M-1:0]  r_dout;
  logic [KW-1:0] r_cnt;
  logic [KW:0]   w_n;
  logic [KW-1:0] w_cnt_next;
  logic [M-1:0]  w_sq;
  logic [M-1:0]  w_stage [UNROLL+1];

  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) t[2*i] = a[i];
    // Fold from the top so each reduction step can feed lower folds.
    for (int j = 2*M-2; j >= M; j--) begin
      if (t[j]) t[j-M +: M] = t[j-M +: M] ^ POLY;
    end
    return t[M-1:0];
  endfunction

  assign w_stage[0] = r_acc;

  genvar gi;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_sq
      assign w_stage[gi+1] = gf_sq(w_stage[gi]);
    end
  endgenerate

  // Never square more times than remain, so cnt cannot wrap.
  always_comb begin
    w_n  = ({1'b0, r_cnt} < UNR) ? {1'b0, r_cnt} : UNR;
    w_sq = w_stage[0];
    for (int i = 1; i <= UNROLL; i++) begin
      if (w_n == (KW+1)'(i)) w_sq = w_stage[i];
    end
    w_cnt_next = r_cnt - w_n[KW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = (bus.k == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_cnt_next == '0) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_acc <= bus.din;
          r_cnt <= bus.k;
          if (bus.k == '0) r_dout <= bus.din;
        end
        S_RUN: begin
          r_acc <= w_sq;
          r_cnt <= w_cnt_next;
          if (w_cnt_next == '0) r_dout <= w_sq;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (r_state == S_IDLE);
  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = (r_state == S_DONE);
  assign bus.dout  = r_dout;

endmodule
